// File: rtl/vga_write_iface.sv
// vga_write_iface: expands one CPU write into the VGA window into up to four
//    SRAM plane writes, applying write modes 0-3 against the read-path latches.
// Ports: wbs_* CPU slave (write only), wbm_* SRAM master (write only),
//    VGA write config and latch0..latch3 held stable by the system accept->ack.
// Latency: 1 accept cycle + one cycle per enabled plane (zero-wait SRAM) + 1 ack
//    cycle; backpressure comes from wbm_ack_i, each plane waits for its SRAM ack.
module vga_write_iface (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [16:1] wbs_adr_i,
   input  logic [1:0]  wbs_sel_i,
   input  logic [15:0] wbs_dat_i,
   input  logic        wbs_stb_i,
   output logic        wbs_ack_o,
   output logic [17:1] wbm_adr_o,
   output logic [1:0]  wbm_sel_o,
   output logic [15:0] wbm_dat_o,
   output logic        wbm_stb_o,
   input  logic        wbm_ack_i,
   input  logic        memory_mapping1,
   input  logic [1:0]  write_mode,
   input  logic [1:0]  raster_op,
   input  logic [2:0]  rotate_count,
   input  logic [7:0]  bit_mask,
   input  logic [3:0]  set_reset,
   input  logic [3:0]  enable_set_reset,
   input  logic [3:0]  map_mask,
   input  logic [7:0]  latch0,
   input  logic [7:0]  latch1,
   input  logic [7:0]  latch2,
   input  logic [7:0]  latch3
);

   typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [15:0] dat_q, dat_d;       // captured CPU data
   logic [14:0] off_q, off_d;       // captured plane offset
   logic [3:0]  pmask_q, pmask_d;   // captured map_mask
   logic [1:0]  plane_q, plane_d;
   logic        stb_q, stb_d;
   logic        ack_q, ack_d;
   logic [16:0] adr_q, adr_d;
   logic [1:0]  sel_q, sel_d;
   logic [15:0] wdat_q, wdat_d;

   logic [14:0] off_in;
   logic [1:0]  first_p, nxt_p, src_p;
   logic        nxt_found;
   logic [15:0] src_dat;
   logic [7:0]  src_l;
   logic [15:0] wr_dat;
   logic        unused_adr;

   assign unused_adr = wbs_adr_i[16];

   function automatic logic [7:0] rotr(input logic [7:0] b, input logic [2:0] n);
      logic [15:0] t;
      t = {b, b} >> n;
      return t[7:0];
   endfunction

   function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] s,
                                      input logic [7:0] l);
      case (op)
         2'b01:   return s & l;
         2'b10:   return s | l;
         2'b11:   return s ^ l;
         default: return s;
      endcase
   endfunction

   // One byte lane of the write datapath for plane p with latch byte l.
   function automatic logic [7:0] plane_byte(input logic [7:0] b, input logic [7:0] l,
                                             input logic [1:0] p, input logic [1:0] mode,
                                             input logic [1:0] op, input logic [2:0] rc,
                                             input logic [7:0] mask, input logic [3:0] sr,
                                             input logic [3:0] esr);
      logic [7:0] d, s, m, r;
      d = rotr(b, rc);
      s = 8'h00;
      m = 8'h00;
      case (mode)
         2'd0: begin
            s = esr[p] ? {8{sr[p]}} : d;
            r = (alu(op, s, l) & mask) | (l & ~mask);
         end
         2'd1: r = l;
         2'd2: begin
            // mode 2 uses the unrotated bit p as a colour fill
            s = {8{b[p]}};
            r = (alu(op, s, l) & mask) | (l & ~mask);
         end
         default: begin
            m = d & mask;
            r = ({8{sr[p]}} & m) | (l & ~m);
         end
      endcase
      return r;
   endfunction

   always_comb begin
      off_in = memory_mapping1 ? {1'b0, wbs_adr_i[14:1]} : wbs_adr_i[15:1];

      // lowest enabled plane for a fresh request
      first_p = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (map_mask[i]) first_p = 2'(i);

      // next enabled plane above the current one
      nxt_p     = 2'd0;
      nxt_found = 1'b0;
      for (int i = 3; i >= 0; i--)
         if (pmask_q[i] && (i > int'(plane_q))) begin
            nxt_p     = 2'(i);
            nxt_found = 1'b1;
         end

      // the datapath is evaluated for the plane about to be presented
      src_dat = (state_q == IDLE) ? wbs_dat_i : dat_q;
      src_p   = (state_q == IDLE) ? first_p : nxt_p;
      case (src_p)
         2'd0:    src_l = latch0;
         2'd1:    src_l = latch1;
         2'd2:    src_l = latch2;
         default: src_l = latch3;
      endcase
      wr_dat = {plane_byte(src_dat[15:8], src_l, src_p, write_mode, raster_op,
                           rotate_count, bit_mask, set_reset, enable_set_reset),
                plane_byte(src_dat[7:0], src_l, src_p, write_mode, raster_op,
                           rotate_count, bit_mask, set_reset, enable_set_reset)};

      state_d = state_q;
      dat_d   = dat_q;
      off_d   = off_q;
      pmask_d = pmask_q;
      plane_d = plane_q;
      stb_d   = stb_q;
      ack_d   = 1'b0;
      adr_d   = adr_q;
      sel_d   = sel_q;
      wdat_d  = wdat_q;

      case (state_q)
         IDLE: begin
            if (wbs_stb_i) begin
               dat_d   = wbs_dat_i;
               off_d   = off_in;
               pmask_d = map_mask;
               sel_d   = wbs_sel_i;
               if (map_mask != 4'd0) begin
                  state_d = WR;
                  plane_d = first_p;
                  stb_d   = 1'b1;
                  adr_d   = {first_p, off_in};
                  wdat_d  = wr_dat;
               end else begin
                  state_d = DONE;
                  ack_d   = 1'b1;
               end
            end
         end
         WR: begin
            if (wbm_ack_i) begin
               if (nxt_found) begin
                  plane_d = nxt_p;
                  adr_d   = {nxt_p, off_q};
                  wdat_d  = wr_dat;
               end else begin
                  stb_d   = 1'b0;
                  state_d = DONE;
                  ack_d   = 1'b1;
               end
            end
         end
         default: begin
            // ack pulse is live during this state; stb is not looked at here
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q <= IDLE;
         dat_q   <= '0;
         off_q   <= '0;
         pmask_q <= '0;
         plane_q <= '0;
         stb_q   <= 1'b0;
         ack_q   <= 1'b0;
         adr_q   <= '0;
         sel_q   <= '0;
         wdat_q  <= '0;
      end else begin
         state_q <= state_d;
         dat_q   <= dat_d;
         off_q   <= off_d;
         pmask_q <= pmask_d;
         plane_q <= plane_d;
         stb_q   <= stb_d;
         ack_q   <= ack_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         wdat_q  <= wdat_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbm_stb_o = stb_q;
   assign wbm_adr_o = adr_q;
   assign wbm_sel_o = sel_q;
   assign wbm_dat_o = wdat_q;

endmodule

// File: tb/tb_vga_write_iface.sv
// tb_vga_write_iface: directed bench for vga_write_iface with an SRAM responder
//    of programmable ack delay and a queue of expected plane writes.
module tb_vga_write_iface;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [16:1] wbs_adr_i;
   logic [1:0]  wbs_sel_i;
   logic [15:0] wbs_dat_i;
   logic        wbs_stb_i;
   logic        wbs_ack_o;
   logic [17:1] wbm_adr_o;
   logic [1:0]  wbm_sel_o;
   logic [15:0] wbm_dat_o;
   logic        wbm_stb_o;
   logic        wbm_ack_i;
   logic        memory_mapping1;
   logic [1:0]  write_mode, raster_op;
   logic [2:0]  rotate_count;
   logic [7:0]  bit_mask;
   logic [3:0]  set_reset, enable_set_reset, map_mask;
   logic [7:0]  latch0, latch1, latch2, latch3;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [16:0] adr;
      logic [15:0] dat;
      logic [1:0]  sel;
   } exp_t;
   exp_t sb_q[$];

   int         ack_delay = 0;
   logic [3:0] wait_cnt  = 4'd0;

   always #5 clk = ~clk;

   vga_write_iface dut (
      .wb_clk_i(clk), .wb_rst_i(rst_n),
      .wbs_adr_i(wbs_adr_i), .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i),
      .wbs_stb_i(wbs_stb_i), .wbs_ack_o(wbs_ack_o),
      .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
      .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
      .memory_mapping1(memory_mapping1), .write_mode(write_mode),
      .raster_op(raster_op), .rotate_count(rotate_count), .bit_mask(bit_mask),
      .set_reset(set_reset), .enable_set_reset(enable_set_reset),
      .map_mask(map_mask),
      .latch0(latch0), .latch1(latch1), .latch2(latch2), .latch3(latch3)
   );

   // SRAM responder: ack after ack_delay idle strobe cycles (0 = same cycle)
   always @(posedge clk) begin
      if (wbm_stb_o && !wbm_ack_i) wait_cnt <= wait_cnt + 4'd1;
      else                         wait_cnt <= 4'd0;
   end
   assign wbm_ack_i = wbm_stb_o && (int'(wait_cnt) >= ack_delay);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] p, input logic [14:0] off,
                       input logic [15:0] dat, input logic [1:0] sel);
      exp_t e;
      e.adr = {p, off};
      e.dat = dat;
      e.sel = sel;
      sb_q.push_back(e);
   endtask

   // every completed SRAM cycle must match the oldest expected write
   always @(negedge clk) begin
      if (rst_n && wbm_stb_o && wbm_ack_i) begin
         chk("sram_write_expected", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sram_adr", 32'(wbm_adr_o), 32'(e.adr));
            chk("sram_dat", 32'(wbm_dat_o), 32'(e.dat));
            chk("sram_sel", 32'(wbm_sel_o), 32'(e.sel));
         end
      end
   end

   // one CPU write; exp_cyc counts the stb cycle as 1 through the ack cycle
   task automatic do_write(input logic [15:0] adr, input logic [15:0] dat,
                           input logic [1:0] sel, input int exp_cyc, input string tag);
      int n;
      bit got;
      @(negedge clk);
      wbs_adr_i = adr;
      wbs_dat_i = dat;
      wbs_sel_i = sel;
      wbs_stb_i = 1'b1;
      n   = 0;
      got = 1'b0;
      while (!got && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (wbs_ack_o) got = 1'b1;
      end
      wbs_stb_i = 1'b0;
      chk({tag, "_ack_seen"}, 32'(got), 32'd1);
      chk({tag, "_latency"}, 32'(n + 1), 32'(exp_cyc));
      @(posedge clk); #1;
      chk({tag, "_ack_one_cycle"}, 32'(wbs_ack_o), 32'd0);
      chk({tag, "_all_planes_written"}, 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      int ack_cnt;
      rst_n = 1'b0;
      wbs_adr_i = '0; wbs_sel_i = '0; wbs_dat_i = '0; wbs_stb_i = 1'b0;
      memory_mapping1 = 1'b0; write_mode = 2'd0; raster_op = 2'd0;
      rotate_count = 3'd0; bit_mask = 8'hFF; set_reset = 4'h0;
      enable_set_reset = 4'h0; map_mask = 4'hF;
      latch0 = 8'h00; latch1 = 8'h00; latch2 = 8'h00; latch3 = 8'h00;
      #1;
      chk("rst_ack", 32'(wbs_ack_o), 32'd0);
      chk("rst_stb", 32'(wbm_stb_o), 32'd0);
      chk("rst_adr", 32'(wbm_adr_o), 32'd0);
      chk("rst_sel", 32'(wbm_sel_o), 32'd0);
      chk("rst_dat", 32'(wbm_dat_o), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // mode 0 pass-through, all planes
      for (int p = 0; p < 4; p++) push(2'(p), 15'h0010, 16'h5AA5, 2'b11);
      do_write(16'h0010, 16'h5AA5, 2'b11, 6, "m0_pass");

      // mode 0 set/reset with partial bit mask
      enable_set_reset = 4'b0101; set_reset = 4'b0001; bit_mask = 8'h0F;
      latch0 = 8'hF0; latch1 = 8'hF0; latch2 = 8'hF0; latch3 = 8'hF0;
      push(2'd0, 15'h0020, 16'hFFFF, 2'b11);
      push(2'd1, 15'h0020, 16'hF0F0, 2'b11);
      push(2'd2, 15'h0020, 16'hF0F0, 2'b11);
      push(2'd3, 15'h0020, 16'hF0F0, 2'b11);
      do_write(16'h0020, 16'h0000, 2'b11, 6, "m0_setreset");

      // mode 1 latch copy, sparse map mask
      write_mode = 2'd1; enable_set_reset = 4'h0; set_reset = 4'h0; bit_mask = 8'hFF;
      latch0 = 8'h11; latch1 = 8'h22; latch2 = 8'h33; latch3 = 8'h44;
      map_mask = 4'b1010;
      push(2'd1, 15'h0030, 16'h2222, 2'b11);
      push(2'd3, 15'h0030, 16'h4444, 2'b11);
      do_write(16'h0030, 16'hBEEF, 2'b11, 4, "m1_copy");

      // mode 3 with rotate
      write_mode = 2'd3; rotate_count = 3'd4; set_reset = 4'hF; map_mask = 4'hF;
      latch0 = 8'h00; latch1 = 8'h00; latch2 = 8'h00; latch3 = 8'h00;
      for (int p = 0; p < 4; p++) push(2'(p), 15'h0040, 16'h00F0, 2'b11);
      do_write(16'h0040, 16'h000F, 2'b11, 6, "m3_rotate");

      // mode 2 XOR, memory_mapping1 folds adr[15] away
      write_mode = 2'd2; raster_op = 2'b11; rotate_count = 3'd0; set_reset = 4'h0;
      memory_mapping1 = 1'b1;
      latch0 = 8'hFF; latch1 = 8'hFF; latch2 = 8'hFF; latch3 = 8'hFF;
      push(2'd0, 15'h0123, 16'hFF00, 2'b11);
      push(2'd1, 15'h0123, 16'hFFFF, 2'b11);
      push(2'd2, 15'h0123, 16'hFF00, 2'b11);
      push(2'd3, 15'h0123, 16'hFFFF, 2'b11);
      do_write(16'hC123, 16'h0005, 2'b11, 6, "m2_xor");

      // mode 0 OR with rotate 1, single byte select, full 15-bit offset
      write_mode = 2'd0; raster_op = 2'b10; rotate_count = 3'd1; memory_mapping1 = 1'b0;
      latch0 = 8'h01; latch1 = 8'h02; latch2 = 8'h04; latch3 = 8'h08;
      push(2'd0, 15'h4123, 16'h4101, 2'b01);
      push(2'd1, 15'h4123, 16'h4203, 2'b01);
      push(2'd2, 15'h4123, 16'h4405, 2'b01);
      push(2'd3, 15'h4123, 16'h4809, 2'b01);
      do_write(16'hC123, 16'h8002, 2'b01, 6, "m0_or_rot");

      // empty map mask: no SRAM cycle at all
      map_mask = 4'h0;
      do_write(16'h0050, 16'h1234, 2'b11, 2, "mask_zero");

      // slow SRAM, reset pulsed while plane 2 is outstanding
      raster_op = 2'b00; rotate_count = 3'd0; map_mask = 4'hF; ack_delay = 3;
      push(2'd0, 15'h0060, 16'h1234, 2'b11);
      push(2'd1, 15'h0060, 16'h1234, 2'b11);
      @(negedge clk);
      wbs_adr_i = 16'h0060; wbs_dat_i = 16'h1234; wbs_sel_i = 2'b11; wbs_stb_i = 1'b1;
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
      chk("slow_planes01_done", 32'(sb_q.size()), 32'd0);
      #1;
      chk("slow_plane2_adr", 32'(wbm_adr_o), 32'({2'd2, 15'h0060}));
      chk("slow_plane2_stb", 32'(wbm_stb_o), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_stb", 32'(wbm_stb_o), 32'd0);
      chk("midrst_ack", 32'(wbs_ack_o), 32'd0);
      chk("midrst_adr", 32'(wbm_adr_o), 32'd0);
      wbs_stb_i = 1'b0;
      ack_cnt = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ack_delay = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (wbs_ack_o || wbm_stb_o) ack_cnt++;
      end
      chk("midrst_no_ack_after", 32'(ack_cnt), 32'd0);

      // next write starts cleanly at plane 0
      for (int p = 0; p < 4; p++) push(2'(p), 15'h0070, 16'hA55A, 2'b10);
      do_write(16'h0070, 16'hA55A, 2'b10, 6, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
